// File: rtl/window_3x3.sv
// window_3x3: streaming 3x3 neighbourhood extractor for a raster pixel stream.
// Two line buffers feed a 3-row shift register; only interior pixels become window centres.

module window_3x3_row #(
   parameter int WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  shift,
   input  logic [WIDTH-1:0]      pix,
   output logic [2:0][WIDTH-1:0] taps_nxt
);
   // Only the two older columns are stored; the newest column is the incoming pixel.
   logic [1:0][WIDTH-1:0] hist;

   assign taps_nxt = {pix, hist};

   always_ff @(posedge clock or negedge reset)
      if (!reset)     hist <= '0;
      else if (shift) hist <= taps_nxt[2:1];
endmodule

module window_3x3 #(
   parameter int WIDTH      = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              pixel_in,
   input  logic                          pixel_valid,
   input  logic                          frame_start,
   output logic [9*WIDTH-1:0]            window,
   output logic                          window_valid,
   output logic [$clog2(IMG_WIDTH)-1:0]  centre_col,
   output logic [$clog2(IMG_HEIGHT)-1:0] centre_row
);
   localparam int            CW       = $clog2(IMG_WIDTH);
   localparam int            RW       = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]              col, cur_col;
   logic [RW-1:0]              row, cur_row;
   logic [WIDTH-1:0]           line1 [IMG_WIDTH];
   logic [WIDTH-1:0]           line2 [IMG_WIDTH];
   logic [2:0][WIDTH-1:0]      col_in;
   logic [2:0][2:0][WIDTH-1:0] taps_nxt;
   logic [8:0][WIDTH-1:0]      win_nxt;
   logic                       qual;

   // frame_start forces the accepted pixel to (0,0) whatever the counters say
   assign cur_col = frame_start ? '0 : col;
   assign cur_row = frame_start ? '0 : row;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (pixel_valid) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col <= cur_col + 1'b1;
            row <= cur_row;
         end
      end

   always_ff @(posedge clock)
      if (pixel_valid) begin
         line2[cur_col] <= line1[cur_col];
         line1[cur_col] <= pixel_in;
      end

   // New right column, top to bottom: two lines up, one line up, current pixel
   assign col_in = {pixel_in, line1[cur_col], line2[cur_col]};

   for (genvar r = 0; r < 3; r++) begin : g_row
      window_3x3_row #(.WIDTH(WIDTH)) u_row (
         .clock    (clock),
         .reset    (reset),
         .shift    (pixel_valid),
         .pix      (col_in[r]),
         .taps_nxt (taps_nxt[r])
      );
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign win_nxt[3*r+c] = taps_nxt[r][c];
      end
   end

   // col>=2 keeps windows that straddle a line wrap from ever being emitted
   assign qual = pixel_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         window_valid <= 1'b0;
         window       <= '0;
         centre_col   <= '0;
         centre_row   <= '0;
      end else begin
         window_valid <= qual;
         if (qual) begin
            window     <= win_nxt;
            centre_col <= cur_col - 1'b1;
            centre_row <= cur_row - 1'b1;
         end
      end
endmodule

// File: tb/tb_window_3x3.sv
// tb_window_3x3: randomized and directed checks of window_3x3 against an image-array reference.

module tb_window_3x3;
   localparam int W = 8, IW = 4, IH = 4;

   logic           clock = 1'b0, reset = 1'b0;
   logic [W-1:0]   pixel_in = '0;
   logic           pixel_valid = 1'b0, frame_start = 1'b0;
   logic [9*W-1:0] window;
   logic           window_valid;
   logic [1:0]     centre_col, centre_row;

   int n_cmp = 0, n_bad = 0;

   window_3x3 #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
      .clock        (clock),
      .reset        (reset),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .frame_start  (frame_start),
      .window       (window),
      .window_valid (window_valid),
      .centre_col   (centre_col),
      .centre_row   (centre_row)
   );

   always #5 clock = ~clock;

   // Reference: the current frame as a 2-D image; a window is the 3x3 patch ending at the accepted pixel.
   logic [W-1:0]   img [IH][IW];
   int             mcol = 0, mrow = 0;
   logic           m_vld = 1'b0;
   logic [9*W-1:0] m_win = '0;
   logic [1:0]     m_cc = '0, m_cr = '0;
   int             acc, pulses, first_at;
   logic [9*W-1:0] first_win;

   localparam logic [9*W-1:0] RAMP_WIN0 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};

   task automatic model_reset();
      mcol = 0; mrow = 0; m_vld = 1'b0; m_win = '0; m_cc = '0; m_cr = '0;
   endtask

   task automatic start();
      acc = 0; pulses = 0; first_at = -1; first_win = '0;
   endtask

   task automatic drive(input logic v, input logic fs, input logic [W-1:0] p);
      @(negedge clock);
      pixel_valid = v; frame_start = fs; pixel_in = p;
      @(posedge clock);
      m_vld = 1'b0;
      if (v) begin
         if (fs) begin mcol = 0; mrow = 0; end
         img[mrow][mcol] = p;
         if (mrow >= 2 && mcol >= 2) begin
            m_vld = 1'b1;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  m_win[W*(3*r+c) +: W] = img[mrow-2+r][mcol-2+c];
            m_cc = 2'(mcol - 1);
            m_cr = 2'(mrow - 1);
         end
         acc++;
         mcol++;
         if (mcol == IW) begin mcol = 0; mrow = (mrow + 1) % IH; end
      end
      #1;
      pixel_valid = 1'b0; frame_start = 1'b0;
      if (window_valid === 1'b1) begin
         pulses++;
         if (first_at < 0) begin first_at = acc; first_win = window; end
      end
   endtask

   function automatic string diag();
      return $sformatf("got v=%b win=%h col=%0d row=%0d, want v=%b win=%h col=%0d row=%0d",
                       window_valid, window, centre_col, centre_row, m_vld, m_win, m_cc, m_cr);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if ({window_valid, window, centre_col, centre_row} !== '0) begin
         n_bad++; $display("FAIL reset_state: %s", diag());
      end
      @(negedge clock) reset = 1'b1;
   endtask

   task automatic test_frame();
      logic [3:0] cq [$];
      logic [3:0] exp_c [4];
      exp_c = '{4'b01_01, 4'b10_01, 4'b01_10, 4'b10_10};
      start();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         if (window_valid === 1'b1) cq.push_back({centre_col, centre_row});
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL frame px%0d: %s", i, diag());
         end
      end
      n_cmp++;
      if (pulses != 4) begin n_bad++; $display("FAIL frame_pulses: got %0d want 4", pulses); end
      n_cmp++;
      if (first_win !== RAMP_WIN0) begin
         n_bad++; $display("FAIL frame_first_win: got %h want %h", first_win, RAMP_WIN0);
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (k >= cq.size() || cq[k] !== exp_c[k]) begin
            n_bad++; $display("FAIL frame_centre%0d: got %h want %h", k, (k < cq.size()) ? cq[k] : 4'hx, exp_c[k]);
         end
      end
   endtask

   task automatic test_gaps();
      start();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i == 0, 8'(i));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL gaps px%0d: %s", i, diag());
         end
         drive(1'b0, 1'b0, 8'($urandom));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL gaps idle%0d: %s", i, diag());
         end
      end
      n_cmp++;
      if (pulses != 4 || first_win !== RAMP_WIN0) begin
         n_bad++; $display("FAIL gaps_summary: got %0d pulses win %h want 4 pulses win %h", pulses, first_win, RAMP_WIN0);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   f [16];
      logic [9*W-1:0] wq [$];
      for (int i = 0; i < 16; i++) f[i] = 8'($urandom);
      start();
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, f[i]);
            if (window_valid === 1'b1) wq.push_back(window);
            n_cmp++;
            if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
               n_bad++; $display("FAIL b2b f%0d px%0d: %s", n, i, diag());
            end
         end
      n_cmp++;
      if (pulses != 8) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (wq.size() < 8 || wq[k+4] !== wq[k]) begin
            n_bad++; $display("FAIL b2b_repeat%0d: got %h want %h", k, (wq.size() >= 8) ? wq[k+4] : 'x, (wq.size() > k) ? wq[k] : 'x);
         end
      end
   endtask

   task automatic test_fs_midframe();
      start();
      for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 8'($urandom));
      start();
      // restart pixel counts as accepted pixel 1; first window expected on pixel 11 (restart + 10)
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i == 0, 8'(i));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL fs_mid px%0d: %s", i, diag());
         end
      end
      n_cmp++;
      if (first_at != 11 || pulses != 4) begin
         n_bad++; $display("FAIL fs_mid_first: got first=%0d pulses=%0d want first=11 pulses=4", first_at, pulses);
      end
      n_cmp++;
      if (first_win !== RAMP_WIN0) begin
         n_bad++; $display("FAIL fs_mid_win: got %h want %h", first_win, RAMP_WIN0);
      end
   endtask

   task automatic test_reset_mid();
      start();
      for (int i = 0; i < 16; i++) drive(1'b1, i == 0, 8'($urandom));
      for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 8'($urandom));
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({window_valid, window, centre_col, centre_row} !== '0) begin
         n_bad++; $display("FAIL reset_async: got v=%b win=%h col=%0d row=%0d want all 0", window_valid, window, centre_col, centre_row);
      end
      model_reset();
      @(negedge clock) reset = 1'b1;
      start();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL reset_mid px%0d: %s", i, diag());
         end
      end
      n_cmp++;
      if (first_at != 11 || pulses != 4 || first_win !== RAMP_WIN0) begin
         n_bad++; $display("FAIL reset_mid_first: got first=%0d pulses=%0d win=%h want first=11 pulses=4 win=%h", first_at, pulses, first_win, RAMP_WIN0);
      end
   endtask

   task automatic test_fs_idle();
      start();
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'(i));
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'($urandom));
         n_cmp++;
         if (window_valid !== 1'b0) begin n_bad++; $display("FAIL fs_idle cyc%0d: got v=%b want 0", i, window_valid); end
      end
      for (int i = 5; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'(i));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL fs_idle px%0d: %s", i, diag());
         end
      end
      n_cmp++;
      if (pulses != 4 || first_win !== RAMP_WIN0) begin
         n_bad++; $display("FAIL fs_idle_summary: got %0d pulses win %h want 4 pulses win %h", pulses, first_win, RAMP_WIN0);
      end
   endtask

   task automatic test_random();
      logic v, fs;
      start();
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         fs = v && ($urandom_range(0, 40) == 0);
         drive(v, fs, 8'($urandom));
         n_cmp++;
         if ({window_valid, window, centre_col, centre_row} !== {m_vld, m_win, m_cc, m_cr}) begin
            n_bad++; $display("FAIL random cyc%0d: %s", i, diag());
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_gaps();
      test_back_to_back();
      test_fs_midframe();
      test_reset_mid();
      test_fs_idle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
